bus_dma: RTL and testbench

BUS_DMA -- requirements
Module: bus_dma

---
 rtl/bus_dma_pkg.sv | 24 ++
 rtl/bus_dma_if.sv | 24 ++
 rtl/bus_tristate_drv.sv | 11 +
 rtl/bus_dma.sv | 145 ++++++++++++++
 tb/tb_bus_dma.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_dma_pkg.sv
// Shared bus package: master FSM encodings, park address and address helper
// used by every master on the shared 8-bit bus.
package bus_dma_pkg;

    localparam logic [7:0] BUS_PARK_ADDR = 8'hFF;
    localparam int         BUS_AW        = 8;
    localparam int         BUS_DW        = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        RD_ADDR = 3'd2,
        RD_WAIT = 3'd3,
        TURN    = 3'd4,
        WR      = 3'd5,
        FIN     = 3'd6
    } dma_state_t;

    // Byte addresses wrap modulo 256 without any error indication.
    function automatic logic [BUS_AW-1:0] addr_inc(input logic [BUS_AW-1:0] a);
        return a + {{(BUS_AW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/bus_dma_if.sv
// Shared-bus ownership and address/control signals; the tristate data lines
// travel as a plain inout so every responder can resolve them.
interface bus_dma_if;

    logic       BUS_REQ;
    logic       BUS_GNT;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;

    modport master (
        output BUS_REQ,
        input  BUS_GNT,
        output BUS_ADDR,
        output BUS_WE
    );

    modport slave (
        input  BUS_REQ,
        output BUS_GNT,
        input  BUS_ADDR,
        input  BUS_WE
    );

endinterface

// File: rtl/bus_tristate_drv.sv
// 8-bit tristate pad driver: drives DATA onto the shared bus when OE is high,
// releases it to high impedance otherwise.
module bus_tristate_drv (
    input  logic       OE,
    input  logic [7:0] DATA,
    inout  wire  [7:0] BUS_DATA
);

    assign BUS_DATA = OE ? DATA : 8'hZZ;

endmodule

// File: rtl/bus_dma.sv
// Byte-copy DMA master on the shared 8-bit bus: reads SRC, writes DST, LEN
// times, four bus cycles per byte (address, wait, turnaround, write).
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter logic [7:0] PARK_ADDR = BUS_PARK_ADDR
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [7:0]       SRC_ADDR,
    input  logic [7:0]       DST_ADDR,
    input  logic [7:0]       LEN,
    output logic             BUSY,
    output logic             DONE,
    bus_dma_if.master        bus,
    inout  wire  [7:0]       BUS_DATA,
    output dma_state_t       DBG_STATE
);

    // Handshakes: START is a one-cycle request accepted only in IDLE; BUS_REQ
    // stays high from REQ through the last WR, and the arbiter holds BUS_GNT
    // until BUS_REQ falls, so GNT is only consulted while in REQ.

    dma_state_t state_q, state_d;

    logic [7:0] src_q, src_d;
    logic [7:0] dst_q, dst_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] buf_q;
    logic       ld_buf;

    logic [7:0] addr_q, addr_d;
    logic       we_q,   we_d;
    logic       oe_q,   oe_d;
    logic       req_q,  req_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            src_q   <= 8'h00;
            dst_q   <= 8'h00;
            rem_q   <= 8'h00;
            buf_q   <= 8'h00;
            addr_q  <= PARK_ADDR;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            if (ld_buf) buf_q <= BUS_DATA;
            addr_q  <= addr_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            req_q   <= req_d;
        end
    end

    // Next state and the copy counters.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        ld_buf  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (LEN == 8'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d = REQ;
                        src_d   = SRC_ADDR;
                        dst_d   = DST_ADDR;
                        rem_d   = LEN;
                    end
                end
            end
            REQ: begin
                if (bus.BUS_GNT) state_d = RD_ADDR;
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                ld_buf  = 1'b1;
                state_d = TURN;
            end
            TURN: state_d = WR;
            WR: begin
                src_d   = addr_inc(src_q);
                dst_d   = addr_inc(dst_q);
                rem_d   = rem_q - 8'd1;
                state_d = (rem_q == 8'd1) ? FIN : RD_ADDR;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        addr_d = PARK_ADDR;
        we_d   = 1'b0;
        oe_d   = 1'b0;
        req_d  = 1'b0;
        case (state_d)
            REQ: req_d = 1'b1;
            RD_ADDR, RD_WAIT: begin
                req_d  = 1'b1;
                addr_d = src_d;
            end
            TURN: req_d = 1'b1;
            WR: begin
                req_d  = 1'b1;
                addr_d = dst_d;
                we_d   = 1'b1;
                oe_d   = 1'b1;
            end
            default: begin
                addr_d = PARK_ADDR;
            end
        endcase
    end

    bus_tristate_drv u_drv (
        .OE       (oe_q),
        .DATA     (buf_q),
        .BUS_DATA (BUS_DATA)
    );

    assign bus.BUS_REQ  = req_q;
    assign bus.BUS_ADDR = addr_q;
    assign bus.BUS_WE   = we_q;
    assign BUSY         = (state_q != IDLE);
    assign DONE         = (state_q == FIN);
    assign DBG_STATE    = state_q;

    // The data pads may only be driven alongside a write strobe.
    always_ff @(posedge CLK) begin
        if (!RESET) assert (!oe_q || we_q);
    end

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: 2-cycle registered RAM model, write scoreboard,
// latency, wrap, grant-wait, busy-START and mid-copy reset cases.
module tb_bus_dma;
    import bus_dma_pkg::*;

    localparam logic [7:0] PARK = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] src, dst, len;
    logic       busy, done;
    dma_state_t dbg;
    wire  [7:0] bus_data;

    bus_dma_if bus_if();

    // RAM model
    logic [7:0] mem  [256];
    logic [7:0] orig [256];
    logic [7:0] ram_q;
    logic       ram_oe;
    logic [7:0] rd_log [$];

    // Scoreboard
    logic [7:0] exp_q [$];
    logic [7:0] exp_a [$];

    int n_checks = 0;
    int n_err    = 0;
    int n_req, n_we, n_done, n_wr, n_extra, n_park_bad;
    int n_contend = 0;

    assign bus_data = ram_oe ? ram_q : 8'hZZ;

    bus_dma #(.PARK_ADDR(PARK)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .START     (start),
        .SRC_ADDR  (src),
        .DST_ADDR  (dst),
        .LEN       (len),
        .BUSY      (busy),
        .DONE      (done),
        .bus       (bus_if.master),
        .BUS_DATA  (bus_data),
        .DBG_STATE (dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered read: address seen in RD_ADDR, data driven the following cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_oe <= 1'b0;
        end else begin
            ram_oe <= (dbg == RD_ADDR) && !bus_if.BUS_WE;
            ram_q  <= mem[bus_if.BUS_ADDR];
            if (dbg == RD_ADDR) rd_log.push_back(bus_if.BUS_ADDR);
        end
    end

    // Mid-cycle write strobe plus monitors.
    always @(negedge clk) begin
        if (bus_if.BUS_WE) begin
            mem[bus_if.BUS_ADDR] <= bus_data;
            n_wr++;
            if (exp_q.size() == 0) begin
                n_extra++;
            end else begin
                check_eq("wr_addr", bus_if.BUS_ADDR, exp_a.pop_front());
                check_eq("wr_data", bus_data, exp_q.pop_front());
            end
        end
        if (ram_oe && bus_if.BUS_WE) n_contend++;
        if (bus_if.BUS_REQ) n_req++;
        if (bus_if.BUS_WE)  n_we++;
        if (done)           n_done++;
    end

    task automatic clear_counts();
        n_req = 0; n_we = 0; n_done = 0; n_wr = 0; n_extra = 0; n_park_bad = 0;
        rd_log.delete();
        for (int i = 0; i < 256; i++) orig[i] = mem[i];
    endtask

    task automatic expect_copy(input logic [7:0] s, input logic [7:0] d, input int l);
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(mem[8'(s + i)]);
            exp_a.push_back(8'(d + i));
        end
    endtask

    // Driver: issue START, optionally hold off the grant or poke START while busy.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int gnt_wait, input bit poke, output int done_cyc);
        int cyc;
        bit got;
        clear_counts();
        expect_copy(s, d, int'(l));
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        if (gnt_wait > 0) bus_if.BUS_GNT = 1'b0;
        cyc = 0; got = 1'b0; done_cyc = -1;
        while (!got && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) check_eq("busy_after_start", busy, 1'b1);
            if (cyc <= gnt_wait + 1 && (bus_if.BUS_ADDR != PARK || ram_oe)) n_park_bad++;
            if (cyc == gnt_wait + 1) bus_if.BUS_GNT = 1'b1;
            if (poke && cyc == 6) begin
                start = 1'b1; src = 8'h80; dst = 8'h90; len = 8'd0;
            end
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
                check_eq("busy_at_done", busy, 1'b1);
            end
        end
        check_eq("done_seen", got, 1'b1);
        @(negedge clk);
        check_eq("done_one_cycle", done, 1'b0);
        check_eq("idle_after_done", busy, 1'b0);
        check_eq("park_while_waiting", n_park_bad, 0);
        check_eq("scoreboard_drained", exp_q.size(), 0);
        check_eq("done_count", n_done, 1);
        for (int i = 0; i < int'(l); i++)
            check_eq("mem_copy", mem[8'(d + i)], orig[8'(s + i)]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"},  bus_if.BUS_ADDR, PARK);
        check_eq({tag, "_we"},    bus_if.BUS_WE, 1'b0);
        check_eq({tag, "_req"},   bus_if.BUS_REQ, 1'b0);
        check_eq({tag, "_busy"},  busy, 1'b0);
        check_eq({tag, "_done"},  done, 1'b0);
        check_eq({tag, "_state"}, dbg, IDLE);
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; src = 8'h00; dst = 8'h00; len = 8'h00;
        bus_if.BUS_GNT = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic 4-byte copy, grant tied high: 2 + 4*LEN cycles to DONE.
        run_copy(8'h10, 8'h40, 8'd4, 0, 1'b0, dc);
        check_eq("latency_len4", dc, 18);

        // LEN=0: straight to FIN, no bus activity.
        run_copy(8'h33, 8'h55, 8'd0, 0, 1'b0, dc);
        check_eq("latency_len0", dc, 1);
        check_eq("len0_no_req", n_req, 0);
        check_eq("len0_no_we", n_we, 0);

        // Source wraps through 8'hFF to 8'h00.
        run_copy(8'hFE, 8'h20, 8'd3, 0, 1'b0, dc);
        check_eq("latency_wrap", dc, 14);
        check_eq("wrap_reads", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check_eq("wrap_rd0", rd_log[0], 8'hFE);
            check_eq("wrap_rd1", rd_log[1], 8'hFF);
            check_eq("wrap_rd2", rd_log[2], 8'h00);
        end

        // Grant held off for 10 cycles.
        run_copy(8'h30, 8'h60, 8'd2, 10, 1'b0, dc);
        check_eq("latency_gnt_wait", dc, 20);

        // START pulsed while busy is ignored.
        run_copy(8'h50, 8'h70, 8'd3, 0, 1'b1, dc);
        check_eq("latency_busy_poke", dc, 14);
        check_eq("busy_poke_writes", n_wr, 3);

        // Reset during the second WR of a 5-byte copy.
        clear_counts();
        expect_copy(8'h08, 8'hA0, 5);
        @(negedge clk);
        start = 1'b1; src = 8'h08; dst = 8'hA0; len = 8'd5;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("pre_reset_state", dbg, WR);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_no_done", n_done, 0);
        check_eq("reset_writes", n_wr, 2);
        check_eq("reset_byte0", mem[8'hA0], orig[8'h08]);
        check_eq("reset_byte1", mem[8'hA1], orig[8'h09]);
        check_eq("reset_byte2_kept", mem[8'hA2], orig[8'hA2]);
        check_eq("reset_byte3_kept", mem[8'hA3], orig[8'hA3]);
        check_eq("reset_byte4_kept", mem[8'hA4], orig[8'hA4]);
        exp_q.delete();
        exp_a.delete();

        // A fresh copy after the abandoned one still works.
        run_copy(8'hC0, 8'hD0, 8'd1, 0, 1'b0, dc);
        check_eq("latency_after_reset", dc, 6);

        check_eq("bus_contention", n_contend, 0);
        check_eq("unexpected_writes", n_extra, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
